// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// access-size decode and the bus FSM state type.
package mem_pkg;

    localparam logic [2:0] LdLb  = 3'b000;
    localparam logic [2:0] LdLh  = 3'b001;
    localparam logic [2:0] LdLw  = 3'b010;
    localparam logic [2:0] LdLd  = 3'b011;
    localparam logic [2:0] LdLbu = 3'b100;
    localparam logic [2:0] LdLhu = 3'b101;
    localparam logic [2:0] LdLwu = 3'b110;
    localparam logic [2:0] LdBad = 3'b111;

    localparam logic [2:0] StSb  = 3'b000;
    localparam logic [2:0] StSh  = 3'b001;
    localparam logic [2:0] StSw  = 3'b010;
    localparam logic [2:0] StSd  = 3'b011;

    typedef enum logic [1:0] {
        MA_IDLE,
        MA_REQ,
        MA_RESP,
        MA_DONE
    } ma_state_e;

    // Access size in bytes for funct3[1:0].
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        logic [3:0] n;
        unique case (sz)
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Byte-lane mask of an access of this size at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        unique case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/grant/response bus; the load/store unit is the master.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 64
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [63:0]       dmem_wdata;
    logic [7:0]        dmem_be;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [63:0]       dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling: store shift and byte enables, alignment check,
// and load extraction with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  st_off_i,
    input  logic [2:0]  st_funct3_i,
    input  logic [63:0] st_data_i,
    input  logic        st_is_load_i,
    output logic [63:0] st_wdata_o,
    output logic [7:0]  st_be_o,
    output logic        aligned_o,
    input  logic [2:0]  ld_off_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [63:0] ld_rdata_i,
    output logic [63:0] ld_data_o
);

    logic [3:0]  sz_m1;
    logic [63:0] ld_shifted;
    logic        ld_signed;

    assign sz_m1      = size_bytes(st_funct3_i[1:0]) - 4'd1;
    assign aligned_o  = (st_off_i & sz_m1[2:0]) == 3'b000;
    assign st_be_o    = size_mask(st_funct3_i[1:0]) << st_off_i;
    // Loads put no data on the bus; only the lane mask is meaningful.
    assign st_wdata_o = st_is_load_i ? 64'd0 : (st_data_i << {st_off_i, 3'b000});

    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    assign ld_signed  = ~ld_funct3_i[2];

    always_comb begin
        ld_data_o = 64'd0;
        unique case (ld_funct3_i[1:0])
            2'b00: ld_data_o = {{56{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01: ld_data_o = {{48{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            2'b10: ld_data_o = {{32{ld_signed & ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns MEM-stage load/store strobes into one
// request/grant/response transaction and stalls the pipeline meanwhile.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_MemRead,
    input  logic               MEM_MemWrite,
    input  logic [63:0]        MEM_ALUresult,
    input  logic [63:0]        MEM_RegData2,
    input  logic [2:0]         MEM_funct3,
    mem_access_unit_if.master  dmem,
    output logic [63:0]        MEM_ReadData,
    output logic               mem_stall,
    output logic               mem_err
);

    ma_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        be_q, be_d;
    logic [2:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              access;
    logic              legal;
    logic              f3_ok;
    logic              aligned;
    logic [63:0]       st_wdata;
    logic [7:0]        st_be;
    logic [63:0]       ld_data;

    mem_lane_align u_lane_align (
        .st_off_i     (MEM_ALUresult[2:0]),
        .st_funct3_i  (MEM_funct3),
        .st_data_i    (MEM_RegData2),
        .st_is_load_i (MEM_MemRead),
        .st_wdata_o   (st_wdata),
        .st_be_o      (st_be),
        .aligned_o    (aligned),
        .ld_off_i     (off_q),
        .ld_funct3_i  (f3_q),
        .ld_rdata_i   (dmem.dmem_rdata),
        .ld_data_o    (ld_data)
    );

    assign access = MEM_MemRead | MEM_MemWrite;
    assign f3_ok  = MEM_MemWrite ? ~MEM_funct3[2] : (MEM_funct3 != LdBad);
    assign legal  = (MEM_MemRead ^ MEM_MemWrite) & f3_ok & aligned;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        off_d     = off_q;
        f3_d      = f3_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        mem_stall = 1'b0;

        unique case (state_q)
            MA_IDLE: begin
                if (access) begin
                    if (legal) begin
                        mem_stall = 1'b1;
                        state_d   = MA_REQ;
                        req_d     = 1'b1;
                        we_d      = MEM_MemWrite;
                        addr_d    = {MEM_ALUresult[ADDR_W-1:3], 3'b000};
                        wdata_d   = st_wdata;
                        be_d      = st_be;
                        off_d     = MEM_ALUresult[2:0];
                        f3_d      = MEM_funct3;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MA_REQ: begin
                mem_stall = 1'b1;
                if (dmem.dmem_gnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? MA_DONE : MA_RESP;
                end
            end
            MA_RESP: begin
                mem_stall = 1'b1;
                if (dmem.dmem_rvalid) begin
                    rdata_d = ld_data;
                    state_d = MA_DONE;
                end
            end
            // Single dead cycle so the still-presented instruction is not re-issued.
            MA_DONE: state_d = MA_IDLE;
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MA_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 64'd0;
            be_q    <= 8'd0;
            off_q   <= 3'd0;
            f3_q    <= 3'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign MEM_ReadData    = rdata_q;
    assign mem_err         = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, illegal accesses,
// reset mid-transaction and back-to-back instructions.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [63:0] alu, rd2;
    logic [2:0]  f3;
    logic [63:0] read_data;
    logic        stall, err;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_grant = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(64)) bus ();

    mem_access_unit #(.ADDR_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .MEM_MemRead   (mem_rd),
        .MEM_MemWrite  (mem_wr),
        .MEM_ALUresult (alu),
        .MEM_RegData2  (rd2),
        .MEM_funct3    (f3),
        .dmem          (bus),
        .MEM_ReadData  (read_data),
        .mem_stall     (stall),
        .mem_err       (err)
    );

    always @(posedge clk) begin
        if (!rst && bus.dmem_req && bus.dmem_gnt) n_grant <= n_grant + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_rd = 1'b0; mem_wr = 1'b0; alu = 64'd0; rd2 = 64'd0; f3 = 3'd0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 64'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%0b want=0", bus.dmem_req); end
        n_cmp++; if (bus.dmem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got=%0b want=0", bus.dmem_we); end
        n_cmp++; if (bus.dmem_addr !== 64'd0) begin n_bad++; $display("FAIL rst_addr got=%h want=0", bus.dmem_addr); end
        n_cmp++; if (bus.dmem_wdata !== 64'd0) begin n_bad++; $display("FAIL rst_wdata got=%h want=0", bus.dmem_wdata); end
        n_cmp++; if (bus.dmem_be !== 8'd0) begin n_bad++; $display("FAIL rst_be got=%h want=0", bus.dmem_be); end
        n_cmp++; if (read_data !== 64'd0) begin n_bad++; $display("FAIL rst_rdata got=%h want=0", read_data); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%0b want=0", err); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%0b want=0", stall); end
    endtask

    task automatic test_store_sd();
        step();
        mem_wr = 1'b1; alu = 64'h1000; rd2 = 64'hDEADBEEF_01234567; f3 = 3'b011;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sd_stall_c1 got=%0b want=1", stall); end
        n_cmp++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL sd_req_c1 got=%0b want=0", bus.dmem_req); end
        step();
        bus.dmem_gnt = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sd_stall_c2 got=%0b want=1", stall); end
        n_cmp++; if (bus.dmem_req !== 1'b1) begin n_bad++; $display("FAIL sd_req got=%0b want=1", bus.dmem_req); end
        n_cmp++; if (bus.dmem_we !== 1'b1) begin n_bad++; $display("FAIL sd_we got=%0b want=1", bus.dmem_we); end
        n_cmp++; if (bus.dmem_be !== 8'hFF) begin n_bad++; $display("FAIL sd_be got=%h want=ff", bus.dmem_be); end
        n_cmp++; if (bus.dmem_addr !== 64'h1000) begin n_bad++; $display("FAIL sd_addr got=%h want=1000", bus.dmem_addr); end
        n_cmp++; if (bus.dmem_wdata !== 64'hDEADBEEF_01234567) begin n_bad++; $display("FAIL sd_wdata got=%h want=deadbeef01234567", bus.dmem_wdata); end
        step();
        bus.dmem_gnt = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sd_stall_done got=%0b want=0", stall); end
        n_cmp++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL sd_req_done got=%0b want=0", bus.dmem_req); end
        clear_inputs();
    endtask

    task automatic test_store_sb();
        step();
        mem_wr = 1'b1; alu = 64'h1005; rd2 = 64'hAB; f3 = 3'b000;
        step();
        bus.dmem_gnt = 1'b1;
        #1;
        n_cmp++; if (bus.dmem_be !== 8'h20) begin n_bad++; $display("FAIL sb_be got=%h want=20", bus.dmem_be); end
        n_cmp++; if (bus.dmem_wdata[47:40] !== 8'hAB) begin n_bad++; $display("FAIL sb_lane got=%h want=ab", bus.dmem_wdata[47:40]); end
        n_cmp++; if (bus.dmem_wdata !== 64'h0000_AB00_0000_0000) begin n_bad++; $display("FAIL sb_wdata got=%h want=0000ab0000000000", bus.dmem_wdata); end
        n_cmp++; if (bus.dmem_addr !== 64'h1000) begin n_bad++; $display("FAIL sb_addr got=%h want=1000", bus.dmem_addr); end
        step();
        clear_inputs();
    endtask

    task automatic test_load_half(input logic [2:0] fn, input logic [63:0] want);
        step();
        mem_rd = 1'b1; alu = 64'h2006; f3 = fn;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lh_stall_c1 f3=%0d got=%0b want=1", fn, stall); end
        step();
        bus.dmem_gnt = 1'b1;
        #1;
        n_cmp++; if (bus.dmem_be !== 8'hC0) begin n_bad++; $display("FAIL lh_be f3=%0d got=%h want=c0", fn, bus.dmem_be); end
        n_cmp++; if (bus.dmem_we !== 1'b0 || bus.dmem_wdata !== 64'd0) begin n_bad++; $display("FAIL lh_rdbus f3=%0d we=%0b wdata=%h want we=0 wdata=0", fn, bus.dmem_we, bus.dmem_wdata); end
        n_cmp++; if (bus.dmem_addr !== 64'h2000) begin n_bad++; $display("FAIL lh_addr f3=%0d got=%h want=2000", fn, bus.dmem_addr); end
        step();
        bus.dmem_gnt = 1'b0;
        bus.dmem_rdata = 64'h1111_2222_3333_4444;
        step();
        #1;
        n_cmp++; if (stall !== 1'b1 || bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL lh_wait f3=%0d stall=%0b req=%0b want stall=1 req=0", fn, stall, bus.dmem_req); end
        step();
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 64'h8001_0000_0000_0000;
        step();
        bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 64'h5555_5555_5555_5555;
        #1;
        n_cmp++; if (read_data !== want) begin n_bad++; $display("FAIL lh_data f3=%0d got=%h want=%h", fn, read_data, want); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lh_stall_done f3=%0d got=%0b want=0", fn, stall); end
        mem_rd = 1'b0;
        step();
        #1;
        n_cmp++; if (read_data !== want) begin n_bad++; $display("FAIL lh_hold f3=%0d got=%h want=%h", fn, read_data, want); end
        clear_inputs();
    endtask

    task automatic test_illegal();
        logic [1:0]  strb [5];
        logic [2:0]  fn   [5];
        logic [63:0] ad   [5];
        strb[0] = 2'b10; fn[0] = 3'b010; ad[0] = 64'h2002;
        strb[1] = 2'b11; fn[1] = 3'b011; ad[1] = 64'h1000;
        strb[2] = 2'b01; fn[2] = 3'b100; ad[2] = 64'h1000;
        strb[3] = 2'b10; fn[3] = 3'b111; ad[3] = 64'h1000;
        strb[4] = 2'b01; fn[4] = 3'b001; ad[4] = 64'h1001;
        for (int i = 0; i < 5; i++) begin
            step();
            mem_rd = strb[i][1]; mem_wr = strb[i][0]; f3 = fn[i]; alu = ad[i];
            #1;
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ill%0d_stall got=%0b want=0", i, stall); end
            step();
            mem_rd = 1'b0; mem_wr = 1'b0;
            #1;
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill%0d_err got=%0b want=1", i, err); end
            n_cmp++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL ill%0d_req got=%0b want=0", i, bus.dmem_req); end
            step();
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ill%0d_pulse got=%0b want=0", i, err); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_resp();
        step();
        mem_rd = 1'b1; alu = 64'h3000; f3 = 3'b011;
        step();
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; mem_rd = 1'b0;
        #1;
        n_cmp++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL rresp_req got=%0b want=0", bus.dmem_req); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rresp_stall got=%0b want=0", stall); end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 64'h1234_5678_9ABC_DEF0;
        step();
        bus.dmem_rvalid = 1'b0;
        #1;
        n_cmp++; if (read_data !== 64'd0) begin n_bad++; $display("FAIL rresp_late got=%h want=0", read_data); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int g0;
        step();
        g0 = n_grant;
        mem_rd = 1'b1; alu = 64'h4008; f3 = 3'b011;
        step();
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 64'hCAFE_F00D_0BAD_BEEF;
        step();
        bus.dmem_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL b2b_done req=%0b stall=%0b want 0 0", bus.dmem_req, stall); end
        n_cmp++; if (read_data !== 64'hCAFE_F00D_0BAD_BEEF) begin n_bad++; $display("FAIL b2b_ld got=%h want=cafef00d0badbeef", read_data); end
        step();
        mem_rd = 1'b0; mem_wr = 1'b1; alu = 64'h4010; rd2 = 64'h0102_0304_0506_0708;
        #1;
        n_cmp++; if (bus.dmem_req !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL b2b_idle req=%0b stall=%0b want 0 1", bus.dmem_req, stall); end
        step();
        bus.dmem_gnt = 1'b1;
        #1;
        n_cmp++; if (bus.dmem_addr !== 64'h4010 || bus.dmem_we !== 1'b1) begin n_bad++; $display("FAIL b2b_sd addr=%h we=%0b want 4010 1", bus.dmem_addr, bus.dmem_we); end
        step();
        bus.dmem_gnt = 1'b0;
        #1;
        mem_wr = 1'b0;
        step();
        step();
        n_cmp++; if (n_grant - g0 !== 2) begin n_bad++; $display("FAIL b2b_grants got=%0d want=2", n_grant - g0); end
        n_cmp++; if (read_data !== 64'hCAFE_F00D_0BAD_BEEF) begin n_bad++; $display("FAIL b2b_hold got=%h want=cafef00d0badbeef", read_data); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_store_sd();
        test_store_sb();
        test_load_half(3'b001, 64'hFFFF_FFFF_FFFF_8001);
        test_load_half(3'b101, 64'h0000_0000_0000_8001);
        test_illegal();
        test_reset_in_resp();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
